// File: rtl/alu_tr_issue.sv
// alu_tr_issue: issue sequencer in front of the time-redundant ALU.
// Accepts one operation per handshake and holds the ALU operands stable for
// WINDOW cycles. It then captures the ALU result, flags and fault into a
// held response and keeps a saturating count of faulted operations.
// Optional feature macro: ALU_TR_RETRY_EN. It allows one re-execution of an
// operation whose first attempt reported a fault.
module alu_tr_issue #(
  parameter int DATA_W = 32,
  parameter int WINDOW = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  input  logic              alu_fault,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic              out_fault,
  output logic [CNT_W-1:0]  fault_cnt
);

  // The hold counter only ever holds values from WINDOW-1 down to 0.
  localparam int HC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [HC_W-1:0] hold_cnt;
  logic            accept;
  logic            capture;
  logic            retry_go;

  // The fault counter sticks at its maximum value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);
  assign accept    = in_valid && in_ready;
  assign capture   = (state == HOLD) && (hold_cnt == '0);

`ifdef ALU_TR_RETRY_EN
  logic retried;
  assign retry_go = capture && alu_fault && !retried;

  // Marks the second attempt so only one retry happens per operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          retried <= 1'b0;
    else if (accept)   retried <= 1'b0;
    else if (retry_go) retried <= 1'b1;
  end
`else
  assign retry_go = 1'b0;
`endif

  // Next-state decode: accept -> hold window -> response -> back to idle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (capture && !retry_go) state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Hold-window counter, reloaded on accept and on a retry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               hold_cnt <= '0;
    else if (accept || retry_go)            hold_cnt <= HOLD_INIT;
    else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - HC_W'(1);
  end

  // Operand registers; they only load in IDLE, so they stay frozen during HOLD and RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else if (accept) begin
      alu_a    <= in_a;
      alu_b    <= in_b;
      alu_ctrl <= in_ctrl;
    end
  end

  // Response capture at the end of each hold window, plus fault counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_result <= '0;
      out_flags  <= '0;
      out_fault  <= 1'b0;
      fault_cnt  <= '0;
    end else if (capture) begin
      out_result <= alu_result;
      out_flags  <= alu_flags;
`ifdef ALU_TR_RETRY_EN
      // A retry keeps the first attempt's fault visible in the response.
      out_fault  <= retried ? (out_fault | alu_fault) : alu_fault;
`else
      out_fault  <= alu_fault;
`endif
      if (alu_fault) fault_cnt <= sat_inc(fault_cnt);
    end
  end

endmodule
